// File: rtl/bankgroup_param.sv
// Two-bank word store used either as random-access RAM or as NCH independent FIFOs.
// Optional macro CBG_STICKY_ERR_EN: err_o holds until rst or flush instead of pulsing.
module bankgroup_param #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 10,
    parameter int unsigned NCH      = 3,
    parameter int unsigned CH_DEPTH = 64
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       en_i,
    input  logic                                       pattern_i,
    input  logic [DW-1:0]                              din_i,
    input  logic [AW-1:0]                              addr_i,
    input  logic                                       we_i,
    input  logic                                       re_i,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]   ch_sel_i,
    input  logic                                       flush_i,
    output logic [DW:0]                                dout_bus,
    output logic [NCH-1:0]                             full_o,
    output logic [NCH-1:0]                             empty_o,
    output logic                                       err_o
);

    localparam int unsigned CSW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned RW    = AW - 1;
    localparam int unsigned DEPTH = 1 << RW;
    localparam int unsigned OW    = $clog2(CH_DEPTH);
    localparam int unsigned PW    = OW + 2;
    localparam logic [RW-1:0] RAND_BASE = RW'(NCH * CH_DEPTH);
    localparam logic [PW-1:0] CAP       = PW'(2 * CH_DEPTH);
    localparam logic [DW:0]   DOUT_IDLE = {1'b0, {DW{1'b1}}};

    logic          en_q, we_q, re_q, flush_q;
    logic          pat_en_q, pat_we_q, pat_addr_q;
    logic [DW-1:0] din_q;
    logic [AW-1:0] addr_q;
    logic [CSW-1:0] ch_q;

    logic [NCH-1:0][PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NCH-1:0]         full_q, full_d, empty_q, empty_d;
    logic [DW:0]            dout_q;
    logic                   err_q, err_d;

    logic          ch_empty, ch_full, push_try, pop_ok, conflict;
    logic          f_push_ok, f_pop_ok, f_err, f_wbank, f_rbank;
    logic [RW-1:0] f_wrow, f_rrow, rnd_row;
    logic          r_rd, r_wr, r_err;
    logic          rd_fire_c, wr_fire_c, rd_bank_c, wr_bank_c, err_c;
    logic [RW-1:0] rd_row_c, wr_row_c;
    logic [DW-1:0] rdata_c;

    logic [DW-1:0] bank0_mem [DEPTH];
    logic [DW-1:0] bank1_mem [DEPTH];

    // Input registers; pattern is held in one copy per consumer group.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            flush_q    <= 1'b0;
            pat_en_q   <= 1'b0;
            pat_we_q   <= 1'b0;
            pat_addr_q <= 1'b0;
            din_q      <= '0;
            addr_q     <= '0;
            ch_q       <= '0;
        end else begin
            en_q       <= en_i;
            we_q       <= we_i;
            re_q       <= re_i;
            flush_q    <= flush_i;
            pat_en_q   <= pattern_i;
            pat_we_q   <= pattern_i;
            pat_addr_q <= pattern_i;
            din_q      <= din_i;
            addr_q     <= addr_i;
            ch_q       <= ch_sel_i;
        end
    end

    // FIFO channel arbitration and pointer next-state.
    always_comb begin
        ch_empty  = 1'b1;
        ch_full   = 1'b0;
        push_try  = 1'b0;
        pop_ok    = 1'b0;
        conflict  = 1'b0;
        f_push_ok = 1'b0;
        f_pop_ok  = 1'b0;
        f_err     = 1'b0;
        f_wbank   = 1'b0;
        f_rbank   = 1'b0;
        f_wrow    = '0;
        f_rrow    = '0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        for (int c = 0; c < NCH; c++) begin
            if (ch_q == CSW'(c)) begin
                ch_empty  = (wr_ptr_q[c] == rd_ptr_q[c]);
                ch_full   = ((wr_ptr_q[c] - rd_ptr_q[c]) == CAP);
                push_try  = we_q & ~ch_full;
                pop_ok    = re_q & ~ch_empty;
                // One port per bank: a pop sharing the push's bank wins.
                conflict  = push_try & pop_ok & (wr_ptr_q[c][0] == rd_ptr_q[c][0]);
                f_push_ok = push_try & ~conflict;
                f_pop_ok  = pop_ok;
                f_err     = (we_q & ch_full) | (re_q & ch_empty) | conflict;
                f_wbank   = wr_ptr_q[c][0];
                f_rbank   = rd_ptr_q[c][0];
                f_wrow    = RW'(c * CH_DEPTH) + RW'(wr_ptr_q[c][OW:1]);
                f_rrow    = RW'(c * CH_DEPTH) + RW'(rd_ptr_q[c][OW:1]);
                if (pat_we_q && f_push_ok) begin
                    wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
                end
                if (pat_en_q && f_pop_ok) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
                end
            end
        end
        if (flush_q) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // Random-mode request decode; a simultaneous write is dropped in favour of the read.
    always_comb begin
        rnd_row = RAND_BASE + addr_q[AW-1:1];
        r_rd    = en_q & re_q;
        r_wr    = en_q & we_q & ~re_q;
        r_err   = en_q & we_q & re_q;
    end

    always_comb begin
        rd_fire_c = ~flush_q & (pat_en_q ? f_pop_ok : r_rd);
        wr_fire_c = ~flush_q & (pat_we_q ? f_push_ok : r_wr);
        err_c     = ~flush_q & (pat_en_q ? f_err : r_err);
        rd_bank_c = pat_addr_q ? f_rbank : addr_q[0];
        wr_bank_c = pat_addr_q ? f_wbank : addr_q[0];
        rd_row_c  = pat_addr_q ? f_rrow  : rnd_row;
        wr_row_c  = pat_addr_q ? f_wrow  : rnd_row;
    end

    always_comb begin
        full_d  = '0;
        empty_d = '0;
        for (int c = 0; c < NCH; c++) begin
            full_d[c]  = ((wr_ptr_d[c] - rd_ptr_d[c]) == CAP);
            empty_d[c] = (wr_ptr_d[c] == rd_ptr_d[c]);
        end
    end

`ifdef CBG_STICKY_ERR_EN
    assign err_d = flush_q ? 1'b0 : (err_q | err_c);
`else
    assign err_d = err_c;
`endif

    // Bank storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire_c && !wr_bank_c) begin
            bank0_mem[wr_row_c] <= din_q;
        end
        if (wr_fire_c && wr_bank_c) begin
            bank1_mem[wr_row_c] <= din_q;
        end
    end

    assign rdata_c = rd_bank_c ? bank1_mem[rd_row_c] : bank0_mem[rd_row_c];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= '0;
            empty_q  <= '1;
            dout_q   <= DOUT_IDLE;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            dout_q   <= rd_fire_c ? {1'b1, rdata_c} : DOUT_IDLE;
            err_q    <= err_d;
        end
    end

    assign dout_bus = dout_q;
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_bankgroup_param.sv
// Bench for bankgroup_param: vector table for FIFO behaviour plus sequences for
// fill/overflow, random mode, flush and reset; read data checked by a scoreboard.
module tb_bankgroup_param;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int NCH = 3;
    localparam logic [DW:0] IDLE = {1'b0, {DW{1'b1}}};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en_i = 1'b0, pattern_i = 1'b0, we_i = 1'b0, re_i = 1'b0, flush_i = 1'b0;
    logic [DW-1:0]  din_i = '0;
    logic [AW-1:0]  addr_i = '0;
    logic [1:0]     ch_sel_i = '0;
    logic [DW:0]    dout_bus;
    logic [NCH-1:0] full_o, empty_o;
    logic           err_o;

    bankgroup_param dut (
        .clk(clk), .rst(rst), .en_i(en_i), .pattern_i(pattern_i), .din_i(din_i),
        .addr_i(addr_i), .we_i(we_i), .re_i(re_i), .ch_sel_i(ch_sel_i),
        .flush_i(flush_i), .dout_bus(dout_bus), .full_o(full_o),
        .empty_o(empty_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          we;
        logic          re;
        logic [1:0]    ch;
        logic [DW-1:0] din;
        logic          rd;
        logic [DW-1:0] rdata;
        logic          err;
        logic [2:0]    empty;
    } vec_t;
    vec_t tbl[19];

    function automatic vec_t mk(input logic we, input logic re, input logic [1:0] ch,
                                input logic [DW-1:0] din, input logic rd,
                                input logic [DW-1:0] rdata, input logic err,
                                input logic [2:0] empty);
        vec_t v;
        v.we = we; v.re = re; v.ch = ch; v.din = din;
        v.rd = rd; v.rdata = rdata; v.err = err; v.empty = empty;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pat, input logic en, input logic we, input logic re,
                         input logic fl, input logic [1:0] ch, input logic [AW-1:0] addr,
                         input logic [DW-1:0] din, input logic exp_rd,
                         input logic [DW-1:0] exp_data);
        exp_t e;
        @(negedge clk);
        pattern_i = pat; en_i = en; we_i = we; re_i = re; flush_i = fl;
        ch_sel_i = ch; addr_i = addr; din_i = din;
        if (exp_rd) begin
            e.due  = cyc + 2;
            e.data = exp_data;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        en_i = 1'b0; we_i = 1'b0; re_i = 1'b0; flush_i = 1'b0;
    endtask

    // Scoreboard: every valid output must match the oldest expectation at its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL rd_missing: got no valid at cycle %0d expected data %0h", e.due, e.data);
        end
        if (dout_bus[DW] === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got %0h at cycle %0d expected no valid", dout_bus, cyc);
            end else begin
                e = sb.pop_front();
                if (e.due != cyc || dout_bus[DW-1:0] !== e.data) begin
                    bad++;
                    $display("FAIL rd_data: got %0h at cycle %0d expected %0h at cycle %0d",
                             dout_bus[DW-1:0], cyc, e.data, e.due);
                end
            end
        end
    end

    initial begin
        tbl[0]  = mk(1, 0, 2'd1, 32'hA0, 0, 0,     0, 3'b101);
        tbl[1]  = mk(1, 0, 2'd1, 32'hA1, 0, 0,     0, 3'b101);
        tbl[2]  = mk(1, 0, 2'd1, 32'hA2, 0, 0,     0, 3'b101);
        tbl[3]  = mk(1, 0, 2'd1, 32'hA3, 0, 0,     0, 3'b101);
        tbl[4]  = mk(0, 1, 2'd1, 0,      1, 32'hA0, 0, 3'b101);
        tbl[5]  = mk(0, 1, 2'd1, 0,      1, 32'hA1, 0, 3'b101);
        tbl[6]  = mk(0, 1, 2'd1, 0,      1, 32'hA2, 0, 3'b101);
        tbl[7]  = mk(0, 1, 2'd1, 0,      1, 32'hA3, 0, 3'b111);
        tbl[8]  = mk(0, 1, 2'd2, 0,      0, 0,     1, 3'b111);
        tbl[9]  = mk(1, 0, 2'd0, 32'h11, 0, 0,     0, 3'b110);
        tbl[10] = mk(1, 0, 2'd0, 32'h22, 0, 0,     0, 3'b110);
        tbl[11] = mk(1, 1, 2'd0, 32'h33, 1, 32'h11, 1, 3'b110);
        tbl[12] = mk(0, 1, 2'd0, 0,      1, 32'h22, 0, 3'b111);
        tbl[13] = mk(0, 1, 2'd0, 0,      0, 0,     1, 3'b111);
        tbl[14] = mk(1, 0, 2'd2, 32'hB0, 0, 0,     0, 3'b011);
        tbl[15] = mk(1, 1, 2'd2, 32'hB1, 1, 32'hB0, 0, 3'b011);
        tbl[16] = mk(0, 1, 2'd2, 0,      1, 32'hB1, 0, 3'b111);
        tbl[17] = mk(1, 0, 2'd3, 32'hC0, 0, 0,     0, 3'b111);
        tbl[18] = mk(0, 1, 2'd3, 0,      0, 0,     0, 3'b111);

        repeat (3) @(negedge clk);
        chk("rst_dout", dout_bus, IDLE);
        chk("rst_empty", empty_o, 3'b111);
        chk("rst_full", full_o, 3'b000);
        chk("rst_err", err_o, 1'b0);
        rst = 1'b0;

        // Isolated single-request vectors in FIFO mode.
        for (int i = 0; i < 19; i++) begin
            drive(1, 0, tbl[i].we, tbl[i].re, 0, tbl[i].ch, '0, tbl[i].din, tbl[i].rd, tbl[i].rdata);
            idle();
            @(negedge clk);
            chk($sformatf("v%0d_err", i), err_o, tbl[i].err);
            chk($sformatf("v%0d_empty", i), empty_o, tbl[i].empty);
            if (!tbl[i].rd) chk($sformatf("v%0d_idle", i), dout_bus, IDLE);
        end

        // Fill channel 0 back-to-back, then overflow it.
        for (int i = 0; i < 128; i++) drive(1, 0, 1, 0, 0, 2'd0, '0, 32'h1000 + i, 0, 0);
        idle();
        @(negedge clk);
        chk("fill_full", full_o, 3'b001);
        chk("fill_empty", empty_o, 3'b110);
        drive(1, 0, 1, 0, 0, 2'd0, '0, 32'hDEAD, 0, 0);
        idle();
        @(negedge clk);
        chk("ovf_err", err_o, 1'b1);
        chk("ovf_full", full_o, 3'b001);

        // Random mode between FIFO intervals; the en_i=0 write must not land.
        drive(0, 1, 1, 0, 0, 2'd0, 10'd5, 32'h1234, 0, 0);
        drive(0, 1, 1, 0, 0, 2'd0, 10'd4, 32'h5678, 0, 0);
        drive(0, 0, 1, 0, 0, 2'd0, 10'd5, 32'hBAD, 0, 0);
        drive(0, 1, 0, 1, 0, 2'd0, 10'd5, '0, 1, 32'h1234);
        drive(0, 1, 0, 1, 0, 2'd0, 10'd4, '0, 1, 32'h5678);
        idle();

        for (int i = 0; i < 128; i++) drive(1, 0, 0, 1, 0, 2'd0, '0, '0, 1, 32'h1000 + i);
        idle();
        @(negedge clk);
        chk("drain_empty", empty_o, 3'b111);
        chk("drain_full", full_o, 3'b000);

        // Flush coincident with a pop on a partially filled channel.
        drive(1, 0, 1, 0, 0, 2'd1, '0, 32'hD0, 0, 0);
        drive(1, 0, 1, 0, 0, 2'd1, '0, 32'hD1, 0, 0);
        drive(1, 0, 1, 0, 0, 2'd1, '0, 32'hD2, 0, 0);
        drive(1, 0, 0, 1, 0, 2'd2, '0, '0, 0, 0);
        idle();
        drive(1, 0, 0, 1, 1, 2'd1, '0, '0, 0, 0);
        idle();
        @(negedge clk);
        chk("flush_empty", empty_o, 3'b111);
        chk("flush_full", full_o, 3'b000);
        chk("flush_err", err_o, 1'b0);
        chk("flush_dout", dout_bus, IDLE);
        drive(1, 0, 1, 0, 0, 2'd1, '0, 32'hE0, 0, 0);
        drive(1, 0, 0, 1, 0, 2'd1, '0, '0, 1, 32'hE0);
        idle();
        @(negedge clk);
        chk("post_flush_empty", empty_o, 3'b111);

        // Reset lands while a pop is in flight.
        drive(1, 0, 1, 0, 0, 2'd1, '0, 32'hF0, 0, 0);
        drive(1, 0, 0, 1, 0, 2'd1, '0, '0, 0, 0);
        @(negedge clk);
        re_i = 1'b0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rstmid_dout", dout_bus, IDLE);
        chk("rstmid_empty", empty_o, 3'b111);
        chk("rstmid_err", err_o, 1'b0);

        repeat (5) idle();
        chk("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bankgroup_param.md
BANKGROUP_PARAM -- requirements
Module: bankgroup_param

Interface
REQ-001 Parameter DW, default 32: data word width in bits.
REQ-002 Parameter AW, default 10: logical address width; bit 0 selects the bank, bits AW-1:1 index within the bank; bank depth is 2^(AW-1).
REQ-003 Parameter NCH, default 3, legal range 1..4: number of FIFO channels.
REQ-004 Parameter CH_DEPTH, default 64, power of 2: words per channel per bank; channel capacity is 2*CH_DEPTH; NCH*CH_DEPTH SHALL be less than 2^(AW-1).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en_i  in  1  random-mode access enable.
REQ-008 pattern_i  in  1  0 = random access, 1 = FIFO mode.
REQ-009 din_i  in  DW  write data.
REQ-010 addr_i  in  AW  random-mode address.
REQ-011 we_i / re_i  in  1 each  write / read (push / pop in FIFO mode).
REQ-012 ch_sel_i  in  clog2(NCH) (min 1)  FIFO channel select; values >= NCH are inert.
REQ-013 flush_i  in  1  clear all channel pointers and any pending read valid.
REQ-014 dout_bus  out  DW+1  {valid, data}; idle value {1'b0, {DW{1'b1}}}.
REQ-015 full_o / empty_o  out  NCH each  per-channel status from registered counters.
REQ-016 err_o  out  1  overflow, underflow or bank-conflict indication.

Function
REQ-017 All inputs SHALL be registered once before use; mode-select fan-out SHALL be replicated into separate registers per consumer group (enable, write, address).
REQ-018 Two single-port banks of 2^(AW-1) x DW; channel c occupies rows [c*CH_DEPTH, (c+1)*CH_DEPTH) in both banks; random region starts at row NCH*CH_DEPTH.
REQ-019 Random mode: registered addr bit 0 selects the bank, and that bank is enabled only when en is high; row = addr[AW-1:1] + NCH*CH_DEPTH, taken modulo bank depth.
REQ-020 FIFO mode: each channel keeps wr_ptr/rd_ptr of clog2(2*CH_DEPTH)+1 bits; ptr bit 0 selects the bank; ptr[clog2(CH_DEPTH):1] is the row offset; the extra MSB distinguishes full from empty.
REQ-021 full = (wr_ptr - rd_ptr == 2*CH_DEPTH); empty = (wr_ptr == rd_ptr).
REQ-022 A push to a full channel SHALL NOT write memory or move wr_ptr, and SHALL assert err; a pop from an empty channel SHALL NOT read memory or move rd_ptr, and SHALL assert err.
REQ-023 Simultaneous push and pop on one channel: if the two pointers select different banks, both complete.
REQ-024 If both pointers select the same bank and the channel is non-empty, the pop wins, the push is dropped and err is asserted.
REQ-025 Pointers wrap modulo 2*CH_DEPTH (MSB toggles) with no bubble.
REQ-026 Read latency: dout_bus valid exactly 2 cycles after a successful re_i (1 input register + 1 RAM); valid is high for 1 cycle per read.
REQ-027 Write in either mode is visible to a read issued 1 or more cycles later.
REQ-028 flush (registered) SHALL zero every channel pointer and clear read valid in the same edge; a read returning in that cycle SHALL be discarded.
REQ-029 A flush coincident with push/pop SHALL take priority; the access is ignored.
REQ-030 A mode change takes effect on registered pattern; FIFO pointers SHALL be preserved across random-mode intervals.

Reset
REQ-031 On rst: all input registers, pointers and the read-valid flag are 0; dout_bus = {1'b0,{DW{1'b1}}}; empty_o = all 1; full_o = 0; err_o = 0.
REQ-032 Reset mid-operation SHALL abort an in-flight read; RAM contents are not cleared.

Configuration
REQ-033 Macro CBG_STICKY_ERR_EN: when defined, err_o is sticky, set by any error event and cleared only by rst or flush.
REQ-034 When CBG_STICKY_ERR_EN is undefined, err_o is a 1-cycle pulse, 1 cycle after the offending registered request.

Verification
REQ-035 Defaults, FIFO ch 1: push 0xA0..0xA3, then 4 pops -> dout_bus = {1,0xA0}..{1,0xA3}, each 2 cycles after its pop; empty_o[1]=1 at end.
REQ-036 Push 128 words to ch 0 -> full_o[0]=1; 129th push -> err_o, and the following 128 pops return the original 128 words in order.
REQ-037 Pop on empty ch 2 -> no valid, dout_bus = {0,0xFFFFFFFF}, err_o asserted.
REQ-038 Random mode: write 0x1234 at addr 5 then 0x5678 at addr 4, read both -> 0x1234 then 0x5678; FIFO ch 0 contents remain unchanged.
REQ-039 Ch 0 holding 2 words, push and pop in the same cycle (same bank) -> pop returns the first word, push is dropped, err_o asserted; count = 1.
REQ-040 Flush with channel partially full and a read in flight -> no valid output, all empty_o=1; sticky err cleared when CBG_STICKY_ERR_EN is defined.
